// File: rtl/btn_press_classifier.sv
// Synchronises and debounces a raw push-button, then classifies each press as
// short or long and emits a one-cycle pulse for each.
module btn_press_classifier #(
   parameter int SYNC_STAGES = 2,
   parameter int DB_CYCLES   = 1_000_000,
   parameter int LONG_CYCLES = 100_000_000
) (
   input  logic clk,
   input  logic reset_n,
   input  logic btn_in,
   output logic btn_db,
   output logic short_pulse,
   output logic long_pulse,
   output logic busy
);

   localparam int DW = $clog2(DB_CYCLES + 1);
   localparam int HW = $clog2(LONG_CYCLES + 1);
   localparam logic [DW-1:0] DB_LAST   = DW'(DB_CYCLES - 1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PRESSED = 2'd1,
      ST_HELD    = 2'd2
   } state_t;

   logic [SYNC_STAGES-1:0] sync_r;
   logic                   sync_s;
   logic                   db_r;
   logic [DW-1:0]          db_cnt_r;
   state_t                 state_r;
   state_t                 state_s;
   logic [HW-1:0]          hold_cnt_r;
   logic [HW-1:0]          hold_cnt_s;
   logic                   short_r;
   logic                   short_s;
   logic                   long_r;
   logic                   long_s;
   logic                   busy_r;
   logic                   busy_s;

   assign sync_s      = sync_r[SYNC_STAGES-1];
   assign btn_db      = db_r;
   assign short_pulse = short_r;
   assign long_pulse  = long_r;
   assign busy        = busy_r;

   // Synchroniser chain for the asynchronous button level.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_r <= {SYNC_STAGES{1'b0}};
      end else begin
         sync_r <= {sync_r[SYNC_STAGES-2:0], btn_in};
      end
   end

   // Debounce: a new level must persist DB_CYCLES edges; any return restarts the count.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         db_r     <= 1'b0;
         db_cnt_r <= {DW{1'b0}};
      end else if (sync_s != db_r) begin
         if (db_cnt_r == DB_LAST) begin
            db_r     <= sync_s;
            db_cnt_r <= {DW{1'b0}};
         end else begin
            db_r     <= db_r;
            db_cnt_r <= db_cnt_r + DW'(1);
         end
      end else begin
         db_r     <= db_r;
         db_cnt_r <= {DW{1'b0}};
      end
   end

   // Classifier next-state and next-output logic; release takes priority over the long limit.
   always_comb begin
      state_s    = state_r;
      hold_cnt_s = hold_cnt_r;
      short_s    = 1'b0;
      long_s     = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (db_r) begin
               state_s    = ST_PRESSED;
               hold_cnt_s = {HW{1'b0}};
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_PRESSED: begin
            if (!db_r) begin
               short_s = 1'b1;
               state_s = ST_IDLE;
            end else if (hold_cnt_r == HOLD_LAST) begin
               long_s  = 1'b1;
               state_s = ST_HELD;
            end else begin
               hold_cnt_s = hold_cnt_r + HW'(1);
            end
         end
         ST_HELD: begin
            if (!db_r) begin
               state_s = ST_IDLE;
            end else begin
               state_s = ST_HELD;
            end
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
      busy_s = (state_s != ST_IDLE);
   end

   // Classifier state and registered outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r    <= ST_IDLE;
         hold_cnt_r <= {HW{1'b0}};
         short_r    <= 1'b0;
         long_r     <= 1'b0;
         busy_r     <= 1'b0;
      end else begin
         state_r    <= state_s;
         hold_cnt_r <= hold_cnt_s;
         short_r    <= short_s;
         long_r     <= long_s;
         busy_r     <= busy_s;
      end
   end

endmodule

// File: tb/tb_btn_press_classifier.sv
// Scoreboard bench for btn_press_classifier: expected pulses (kind, cycle) are
// queued when a press is driven and compared when the DUT pulses.
module tb_btn_press_classifier;

   localparam int SYNC = 2;
   localparam int DB   = 4;
   localparam int LONG = 20;
   localparam int RISE = SYNC + DB;           // input change -> btn_db edge
   localparam int LONG_AT = RISE + 1 + LONG;  // press start -> long_pulse

   logic clk = 1'b0;
   logic reset_n;
   logic btn_in;
   logic btn_db;
   logic short_pulse;
   logic long_pulse;
   logic busy;

   int cyc = 0;
   int n_checks = 0;
   int n_pass = 0;
   int exp_kind[$];
   int exp_cyc[$];
   int db_rises = 0;
   int db_falls = 0;
   logic db_prev = 1'b0;

   btn_press_classifier #(
      .SYNC_STAGES(SYNC),
      .DB_CYCLES  (DB),
      .LONG_CYCLES(LONG)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .btn_in     (btn_in),
      .btn_db     (btn_db),
      .short_pulse(short_pulse),
      .long_pulse (long_pulse),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_val(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs == exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0d expected %0d at cycle %0d", tag, obs, exp, cyc);
      end
   endtask

   task automatic push_exp(input int kind, input int at);
      exp_kind.push_back(kind);
      exp_cyc.push_back(at);
   endtask

   task automatic monitor_step();
      int k;
      int c;
      if (short_pulse || long_pulse) begin
         if (exp_kind.size() == 0) begin
            check_val("unexpected_pulse", {30'd0, long_pulse, short_pulse}, 0);
         end else begin
            k = exp_kind.pop_front();
            c = exp_cyc.pop_front();
            check_val("pulse_kind", {30'd0, long_pulse, short_pulse}, k);
            check_val("pulse_cycle", cyc, c);
         end
      end
      if (btn_db && !db_prev) db_rises++;
      if (!btn_db && db_prev) db_falls++;
      db_prev = btn_db;
   endtask

   always @(negedge clk) monitor_step();

   // Button is already high since just after edge k0; hold until k0+h, release, watch.
   task automatic run_press(input int k0, input int h);
      int r0;
      if (h <= LONG) push_exp(1, k0 + h + RISE + 1);
      else           push_exp(2, k0 + LONG_AT);
      while (cyc < k0 + h) begin
         @(negedge clk);
         check_val("db_press", btn_db, int'((cyc - k0) >= RISE));
         check_val("busy_press", busy, int'((cyc - k0) >= RISE + 1));
      end
      btn_in = 1'b0;
      r0 = cyc;
      repeat (12) begin
         @(negedge clk);
         check_val("db_release", btn_db, int'((cyc - r0) < RISE));
         check_val("busy_release", busy, int'((cyc - r0) < RISE + 1));
      end
      check_val("queue_drained", exp_kind.size(), 0);
   endtask

   task automatic press(input int h);
      btn_in = 1'b1;
      run_press(cyc, h);
   endtask

   task automatic quiet_cycles(input int n);
      repeat (n) begin
         @(negedge clk);
         check_val("quiet_db", btn_db, 0);
         check_val("quiet_busy", busy, 0);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int k0;
      int r0;
      reset_n = 1'b0;
      btn_in  = 1'b0;
      #12;
      check_val("reset_db", btn_db, 0);
      check_val("reset_short", short_pulse, 0);
      check_val("reset_long", long_pulse, 0);
      check_val("reset_busy", busy, 0);
      @(negedge clk);
      reset_n = 1'b1;
      quiet_cycles(5);

      // clean short press and long press
      press(10);
      press(40);

      // glitches of 1..3 cycles are rejected
      db_rises = 0;
      for (int g = 1; g <= 3; g++) begin
         btn_in = 1'b1;
         quiet_cycles(g);
         btn_in = 1'b0;
         quiet_cycles(5);
      end
      check_val("glitch_rises", db_rises, 0);

      // bouncy press and bouncy release
      db_rises = 0;
      db_falls = 0;
      for (int b = 0; b < 3; b++) begin
         btn_in = 1'b1;
         quiet_cycles(2);
         btn_in = 1'b0;
         quiet_cycles(2);
      end
      btn_in = 1'b1;
      k0 = cyc;
      repeat (10) @(negedge clk);
      for (int b = 0; b < 2; b++) begin
         btn_in = 1'b0;
         @(negedge clk);
         btn_in = 1'b1;
         @(negedge clk);
      end
      btn_in = 1'b0;
      r0 = cyc;
      if (r0 - k0 <= LONG) push_exp(1, r0 + RISE + 1);
      else                 push_exp(2, k0 + LONG_AT);
      repeat (12) @(negedge clk);
      check_val("bounce_rises", db_rises, 1);
      check_val("bounce_falls", db_falls, 1);
      check_val("bounce_busy", busy, 0);
      check_val("bounce_drained", exp_kind.size(), 0);

      // release exactly at the limit wins; one cycle later is long
      press(LONG);
      press(LONG + 1);

      // reset mid-hold, button kept down
      btn_in = 1'b1;
      repeat (17) @(negedge clk);
      check_val("pre_reset_busy", busy, 1);
      check_val("pre_reset_db", btn_db, 1);
      #2;
      reset_n = 1'b0;
      #1;
      check_val("mid_reset_db", btn_db, 0);
      check_val("mid_reset_busy", busy, 0);
      check_val("mid_reset_short", short_pulse, 0);
      check_val("mid_reset_long", long_pulse, 0);
      @(negedge clk);
      reset_n = 1'b1;
      run_press(cyc, 30);

      quiet_cycles(5);
      check_val("final_queue", exp_kind.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/btn_press_classifier.md
Name: btn_press_classifier

Overview:
- Upstream conditioner for the fan/LED step controllers.
- Takes a raw, bouncy, asynchronous push-button input and synchronises and debounces it.
- Classifies each press as short or long and emits one-cycle pulses.
- short_pulse drives the step controller's advance input (btn); long_pulse drives its clear input (led_clr).

Parameters:
- SYNC_STAGES, 2: synchroniser flop count (>=2).
- DB_CYCLES, 1_000_000: consecutive cycles a changed level must persist before it is accepted (10 ms at 100 MHz); >=1.
- LONG_CYCLES, 100_000_000: cycles the debounced button must stay high to count as a long press (1 s at 100 MHz); >=1.

Ports:
- clk  input  1  system clock, 100 MHz.
- reset_n  input  1  reset, asynchronous assert, active-low.
- btn_in  input  1  raw button level, active-high, asynchronous to clk.
- btn_db  output  1  debounced, synchronised button level.
- short_pulse  output  1  one-cycle pulse: a press released before LONG_CYCLES.
- long_pulse  output  1  one-cycle pulse: a press held for LONG_CYCLES.
- busy  output  1  high while a press is in progress (FSM in PRESSED or HELD).

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset (reset_n=0): all synchroniser flops, btn_db, counters, short_pulse, long_pulse and busy are 0; FSM goes to IDLE. Assertion takes effect immediately, independent of clk.

Synchroniser:
- SYNC_STAGES-flop chain on btn_in.
- The last stage (sync) is the only signal used downstream.

Debounce:
- db_cnt, width $clog2(DB_CYCLES+1).
- Each edge where sync != btn_db: db_cnt increments.
- When db_cnt == DB_CYCLES-1 at that edge: btn_db <= sync and db_cnt <= 0.
- Any edge where sync == btn_db: db_cnt <= 0. Glitches shorter than DB_CYCLES are therefore fully rejected and the count restarts.
- Latency: a clean step on btn_in appears on btn_db exactly SYNC_STAGES+DB_CYCLES edges after the first edge that samples the new level.

FSM (states IDLE, PRESSED, HELD; all outputs registered):
- IDLE:
  - btn_db==1 -> PRESSED, hold_cnt <= 0.
- PRESSED (busy=1):
  - Release is checked first. btn_db==0 -> short_pulse=1 for one cycle, -> IDLE.
  - Else if hold_cnt == LONG_CYCLES-1 -> long_pulse=1 for one cycle, -> HELD.
  - Else hold_cnt increments.
- HELD (busy=1):
  - Waits for btn_db==0, then -> IDLE.
  - No short_pulse on this release; no further long_pulse.
- hold_cnt width is $clog2(LONG_CYCLES+1). It saturates and never wraps.
- short_pulse and long_pulse are never high in the same cycle. Each is high for at most 1 cycle per press.

Boundary cases:
- Release in the very cycle hold_cnt reaches its limit: release wins, so short_pulse fires and long_pulse does not.
- Button held through reset deassertion: treated as a fresh press. btn_db rises after SYNC_STAGES+DB_CYCLES edges, then normal classification applies.
- Reset mid-press: any pending pulse is dropped and no pulse is emitted for that press.
- Bounce during release: btn_db stays high until DB_CYCLES stable low cycles, so exactly one short_pulse or one long_pulse per physical press.

Test Plan (DB_CYCLES=4, LONG_CYCLES=20, SYNC_STAGES=2):
- Clean press, 10-cycle hold, release: btn_db rises 6 edges after the press and falls 6 edges after the release. Exactly one short_pulse, 1 cycle wide, the cycle after btn_db falls. long_pulse never asserts.
- Hold 40 cycles: long_pulse exactly once, 1 cycle wide, after btn_db has been high for 20 cycles. busy stays high until btn_db falls. No short_pulse on release.
- Glitches of 1, 2 and 3 cycles on btn_in, separated by 5 low cycles: btn_db stays 0, no pulses, busy stays 0.
- Press with 3 bounces (2-cycle high/low toggles) before steady high for 10 cycles, then release with bounces: one btn_db rise, one fall, exactly one short_pulse.
- Release timed so btn_db falls on the edge hold_cnt would reach 19: short_pulse=1, long_pulse=0.
- reset_n pulsed low for 1 cycle mid-hold (hold_cnt≈10), button still held: outputs 0 immediately. btn_db re-rises 6 edges after reset release; a subsequent 30-cycle hold yields one long_pulse.
